// File: rtl/pwm_sample_scheduler.sv
// PWM sample scheduler: FIFO-buffered producer samples, released to the PWM
// only on frame boundaries, with priming, underrun counting and enable/mute.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              playback enable
//   s_data/s_valid  producer sample and valid
//   s_ready         FIFO can accept a sample this cycle
//   sample          registered value for the PWM sample input
//   frame_start     high for the cycle frame_cnt==0
//   fifo_level      current FIFO occupancy
//   underrun_cnt    saturating underrun counter
//   clr_underrun    synchronous clear of underrun_cnt
module pwm_sample_scheduler #(
    parameter int          PERIOD      = 255,
    parameter int          DEPTH       = 4,
    parameter int          PRIME_LVL   = 2,
    parameter int          HOLD_FRAMES = 1,
    parameter logic [7:0]  IDLE_LEVEL  = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [7:0]                   s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [7:0]                   sample,
    output logic                         frame_start,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [7:0]                   underrun_cnt,
    input  logic                         clr_underrun
);

    localparam int FW = $clog2(PERIOD);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    typedef enum logic [1:0] {
        S_DIS,
        S_PRIME,
        S_RUN
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [FW-1:0]  frame_cnt;
    logic [HW-1:0]  hold_cnt;
    logic [HW-1:0]  hold_nx;
    logic [7:0]     mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [LW-1:0]  level;

    logic boundary;
    logic pop_slot;
    logic push;
    logic pop;
    logic flush;
    logic underrun;
    logic idle_load;

    assign boundary   = (frame_cnt == FW'(PERIOD - 1));
    assign pop_slot   = boundary && (hold_cnt == HW'(HOLD_FRAMES - 1));
    assign s_ready    = (state != S_DIS) && (level < LW'(DEPTH));
    // A flush (en low) discards any sample offered in the same cycle.
    assign push       = s_valid && s_ready && en;
    assign fifo_level = level;

    always_comb begin
        state_nx  = state;
        hold_nx   = hold_cnt;
        pop       = 1'b0;
        underrun  = 1'b0;
        flush     = 1'b0;
        idle_load = 1'b0;
        if (!en) begin
            state_nx  = S_DIS;
            flush     = 1'b1;
            idle_load = boundary;
        end else begin
            unique case (state)
                S_DIS: begin
                    flush     = 1'b1;
                    idle_load = boundary;
                    state_nx  = S_PRIME;
                    hold_nx   = '0;
                end
                S_PRIME: begin
                    if (boundary && (level >= LW'(PRIME_LVL))) begin
                        pop      = 1'b1;
                        state_nx = S_RUN;
                        hold_nx  = '0;
                    end
                end
                S_RUN: begin
                    if (pop_slot) begin
                        hold_nx = '0;
                        if (level != '0) begin
                            pop = 1'b1;
                        end else begin
                            underrun = 1'b1;
                            state_nx = S_PRIME;
                        end
                    end else if (boundary) begin
                        hold_nx = hold_cnt + HW'(1);
                    end
                end
                default: state_nx = S_DIS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            frame_start <= 1'b0;
            state       <= S_DIS;
            hold_cnt    <= '0;
        end else begin
            frame_cnt   <= boundary ? '0 : frame_cnt + FW'(1);
            frame_start <= boundary;
            state       <= state_nx;
            hold_cnt    <= hold_nx;
        end
    end

    // pop and idle_load only ever assert on a boundary cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= IDLE_LEVEL;
        end else if (idle_load) begin
            sample <= IDLE_LEVEL;
        end else if (pop) begin
            sample <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (clr_underrun) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Bench for pwm_sample_scheduler: directed frame-level scenarios plus random
// traffic, two instances (hold 1 and hold 3) checked against a reference model.
module tb_pwm_sample_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] s_data;
    logic       s_valid;
    logic       clr_underrun;

    logic       rdy [2];
    logic [7:0] smp [2];
    logic       fs  [2];
    logic [2:0] lvl [2];
    logic [7:0] ur  [2];

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    always #5 clk = ~clk;

    pwm_sample_scheduler u0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[0]),
        .sample(smp[0]), .frame_start(fs[0]), .fifo_level(lvl[0]),
        .underrun_cnt(ur[0]), .clr_underrun(clr_underrun)
    );

    pwm_sample_scheduler #(.HOLD_FRAMES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[1]),
        .sample(smp[1]), .frame_start(fs[1]), .fifo_level(lvl[1]),
        .underrun_cnt(ur[1]), .clr_underrun(clr_underrun)
    );

    // Reference model: mode 0=disabled 1=priming 2=playing; FIFO is a
    // shift array where entry 0 is the oldest sample.
    int         m_md [2];
    int         m_pos[2];
    int         m_frm[2];
    int         m_n  [2];
    int         m_ur [2];
    logic [7:0] m_q  [2][4];
    logic [7:0] m_smp[2];
    bit         m_fs [2];

    task automatic mdl_reset();
        for (int k = 0; k < 2; k++) begin
            m_md[k] = 0; m_pos[k] = 0; m_frm[k] = 0;
            m_n[k] = 0; m_ur[k] = 0; m_smp[k] = 8'h00; m_fs[k] = 0;
        end
    endtask

    task automatic mdl_step(input int k, input int hold);
        bit last_cycle = (m_pos[k] == 254);
        bit accept = s_valid && en && (m_md[k] != 0) && (m_n[k] < 4);
        bit take = 0;
        bit starve = 0;
        m_fs[k]  = last_cycle;
        m_pos[k] = last_cycle ? 0 : m_pos[k] + 1;
        if (!en || m_md[k] == 0) begin
            if (last_cycle) m_smp[k] = 8'h00;
            m_n[k] = 0;
            if (en) begin
                m_md[k] = 1;
                m_frm[k] = 0;
            end else begin
                m_md[k] = 0;
            end
        end else if (m_md[k] == 1) begin
            if (last_cycle && m_n[k] >= 2) begin
                take = 1; m_md[k] = 2; m_frm[k] = 0;
            end
        end else if (last_cycle) begin
            if (m_frm[k] == hold - 1) begin
                m_frm[k] = 0;
                if (m_n[k] > 0) take = 1;
                else begin starve = 1; m_md[k] = 1; end
            end else begin
                m_frm[k]++;
            end
        end
        if (take) begin
            m_smp[k] = m_q[k][0];
            for (int i = 0; i < 3; i++) m_q[k][i] = m_q[k][i+1];
            m_n[k]--;
        end
        if (accept) begin
            m_q[k][m_n[k]] = s_data;
            m_n[k]++;
        end
        if (clr_underrun) m_ur[k] = 0;
        else if (starve && m_ur[k] < 255) m_ur[k]++;
    endtask

    always @(negedge rst_n) mdl_reset();

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            mdl_step(0, 1);
            mdl_step(1, 3);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 25)
                $display("FAIL %s actual=%0h required=%0h t=%0t",
                         name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d.sample", k), 32'(smp[k]), 32'(m_smp[k]));
                chk($sformatf("m%0d.frame_start", k), 32'(fs[k]), 32'(m_fs[k]));
                chk($sformatf("m%0d.s_ready", k), 32'(rdy[k]),
                    32'((m_md[k] != 0) && (m_n[k] < 4)));
                chk($sformatf("m%0d.fifo_level", k), 32'(lvl[k]), 32'(m_n[k]));
                chk($sformatf("m%0d.underrun_cnt", k), 32'(ur[k]), 32'(m_ur[k]));
            end
        end
    end

    task automatic push(input logic [7:0] d);
        bit done = 0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (rdy[0]) done = 1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    // Ends on the negedge inside the frame_cnt==0 cycle.
    task automatic wait_fs();
        bit got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (fs[0]) got = 1;
        end
        if (!got) chk("wait_frame_start", 0, 1);
    endtask

    task automatic reset_lits(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, ".sample"}, 32'(smp[k]), 32'h00);
            chk({tag, ".frame_start"}, 32'(fs[k]), 0);
            chk({tag, ".s_ready"}, 32'(rdy[k]), 0);
            chk({tag, ".fifo_level"}, 32'(lvl[k]), 0);
            chk({tag, ".underrun_cnt"}, 32'(ur[k]), 0);
        end
    endtask

    task automatic random_traffic(input int cycles);
        int rate = 250;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (c % 2000 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rate = 60;
                    1:       rate = 250;
                    default: rate = 500;
                endcase
            end
            s_valid = ($urandom_range(0, rate) == 0);
            s_data  = 8'($urandom);
            clr_underrun = ($urandom_range(0, 3999) == 0);
            if ($urandom_range(0, 2999) == 0) en = ~en;
        end
        s_valid = 1'b0;
        clr_underrun = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; s_data = 8'h00;
        s_valid = 1'b0; clr_underrun = 1'b0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #2;
        reset_lits("rst");
        rst_n = 1'b1;
        started = 1;

        // Priming and first two samples.
        @(posedge clk); #1;
        en = 1'b1;
        push(8'hA5);
        push(8'h3C);
        @(negedge clk);
        chk("primed.level", 32'(lvl[0]), 2);
        wait_fs();
        chk("fs1.sample", 32'(smp[0]), 32'hA5);
        chk("fs1.h3.sample", 32'(smp[1]), 32'hA5);
        chk("fs1.level", 32'(lvl[0]), 1);
        wait_fs();
        chk("fs2.sample", 32'(smp[0]), 32'h3C);
        chk("fs2.h3.sample", 32'(smp[1]), 32'hA5);
        wait_fs();
        chk("underrun.sample", 32'(smp[0]), 32'h3C);
        chk("underrun.cnt", 32'(ur[0]), 1);
        chk("underrun.s_ready", 32'(rdy[0]), 1);

        // Fill to full.
        @(posedge clk); #1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        @(negedge clk);
        chk("full.s_ready", 32'(rdy[0]), 0);
        chk("full.level", 32'(lvl[0]), 4);
        wait_fs();
        chk("run.sample", 32'(smp[0]), 32'h11);
        chk("run.level", 32'(lvl[0]), 3);

        // Disable mid-frame at frame_cnt==100.
        repeat (100) @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk); #1;
        chk("dis.sample_held", 32'(smp[0]), 32'h11);
        chk("dis.level", 32'(lvl[0]), 0);
        chk("dis.s_ready", 32'(rdy[0]), 0);
        wait_fs();
        chk("dis.sample_idle", 32'(smp[0]), 32'h00);

        // Clear coinciding with an underrun.
        @(posedge clk); #1;
        en = 1'b1;
        push(8'h5A);
        push(8'h6B);
        wait_fs();
        chk("re.sample1", 32'(smp[0]), 32'h5A);
        wait_fs();
        chk("re.sample2", 32'(smp[0]), 32'h6B);
        repeat (254) @(posedge clk);
        #1;
        clr_underrun = 1'b1;
        @(posedge clk); #1;
        clr_underrun = 1'b0;
        @(negedge clk);
        chk("clr_wins.cnt", 32'(ur[0]), 0);
        chk("clr_wins.s_ready", 32'(rdy[0]), 1);

        random_traffic(12000);

        // Asynchronous reset in the middle of a frame.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        reset_lits("arst");
        @(negedge clk); #2;
        rst_n = 1'b1;

        random_traffic(12000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
